// File: rtl/gain_mult_sched_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// gain_mult_sched_if : sample/config/multiplier/result bundle of gain_mult_sched
// Rev 1.0
// -----------------------------------------------------------------------------
interface gain_mult_sched_if #(
  parameter int N_CH     = 4,
  parameter int A_WDT    = 16,
  parameter int COEF_WDT = 16
);
  localparam int CH_W = $clog2(N_CH);

  logic [N_CH-1:0]       reqSt;
  logic [N_CH*A_WDT-1:0] reqA;
  logic                  cfgWr;
  logic [CH_W-1:0]       cfgCh;
  logic [COEF_WDT-1:0]   cfgCoef;
  logic                  ovfClr;
  logic [N_CH-1:0]       ovf;
  logic                  multSt;
  logic [A_WDT-1:0]      multA;
  logic [COEF_WDT-1:0]   multCoef;
  logic                  multRdy;
  logic [A_WDT-1:0]      multY;
  logic                  outVld;
  logic [CH_W-1:0]       outCh;
  logic [A_WDT-1:0]      outY;

  modport slave (
    input  reqSt, reqA, cfgWr, cfgCh, cfgCoef, ovfClr, multRdy, multY,
    output ovf, multSt, multA, multCoef, outVld, outCh, outY
  );

  modport master (
    output reqSt, reqA, cfgWr, cfgCh, cfgCoef, ovfClr, multRdy, multY,
    input  ovf, multSt, multA, multCoef, outVld, outCh, outY
  );
endinterface
`default_nettype wire

// File: rtl/gain_mult_sched.sv
`default_nettype none
// -----------------------------------------------------------------------------
// gain_mult_sched : round-robin time-sharing of one saturating gain multiplier
// across N_CH channels; GAIN_SCHED_RAMP_EN enables slewed coefficient updates.
// Rev 1.0
// -----------------------------------------------------------------------------
module gain_mult_sched #(
  parameter int N_CH      = 4,
  parameter int A_WDT     = 16,
  parameter int COEF_WDT  = 16,
  parameter int MULT_LAT  = 2,
  parameter int RAMP_STEP = 16
) (
  input  logic             clk,
  input  logic             reset,
  gain_mult_sched_if.slave bus
);
  localparam int                  CH_W    = $clog2(N_CH);
  localparam logic [CH_W:0]       C_NCH   = (CH_W+1)'(N_CH);
  localparam logic [COEF_WDT-1:0] C_UNITY = COEF_WDT'(1) << (COEF_WDT/2);

  if (N_CH < 2 || N_CH > 16 || (COEF_WDT % 2) != 0 || COEF_WDT > 32 ||
      MULT_LAT < 1 || RAMP_STEP < 1) begin : g_bad_param
    $error("gain_mult_sched: illegal parameter set");
  end

  logic [N_CH-1:0]     r_pend;
  logic [N_CH-1:0]     r_ovf;
  logic [A_WDT-1:0]    r_buf  [N_CH];
  logic [COEF_WDT-1:0] r_coef [N_CH];
  logic [CH_W-1:0]     r_rrPtr;
  logic [A_WDT-1:0]    r_multA;
  logic [COEF_WDT-1:0] r_multCoef;
  logic [MULT_LAT:0]   r_tagVld;
  logic [CH_W-1:0]     r_tagCh [MULT_LAT+1];
  logic                r_outVld;
  logic [CH_W-1:0]     r_outCh;
  logic [A_WDT-1:0]    r_outY;

  logic                w_gntVld;
  logic [CH_W-1:0]     w_gnt;
  logic [CH_W:0]       w_idx;
  logic [CH_W-1:0]     w_gntNext;
  logic [N_CH-1:0]     w_issVec;
  logic                w_cfgHit;
  logic [N_CH-1:0]     w_cfgVec;

  // Descending scan so the last hit, i.e. the nearest channel at/after rrPtr, wins.
  always_comb begin
    w_gntVld = 1'b0;
    w_gnt    = '0;
    w_idx    = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_rrPtr} + (CH_W+1)'(k);
      if (w_idx >= C_NCH) begin
        w_idx = w_idx - C_NCH;
      end
      if (r_pend[w_idx[CH_W-1:0]]) begin
        w_gntVld = 1'b1;
        w_gnt    = w_idx[CH_W-1:0];
      end
    end
  end

  assign w_gntNext = ({1'b0, w_gnt} == C_NCH - 1'b1) ? '0 : w_gnt + 1'b1;
  assign w_issVec  = w_gntVld ? (N_CH'(1) << w_gnt) : '0;
  assign w_cfgHit  = bus.cfgWr && ({1'b0, bus.cfgCh} < C_NCH);
  assign w_cfgVec  = w_cfgHit ? (N_CH'(1) << bus.cfgCh) : '0;

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (bus.reqSt[i]) begin
        r_buf[i] <= bus.reqA[i*A_WDT +: A_WDT];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend     <= '0;
      r_ovf      <= '0;
      r_rrPtr    <= '0;
      r_multA    <= '0;
      r_multCoef <= '0;
      r_tagVld   <= '0;
      r_outVld   <= 1'b0;
      r_outCh    <= '0;
      r_outY     <= '0;
      for (int k = 0; k <= MULT_LAT; k++) begin
        r_tagCh[k] <= '0;
      end
    end else begin
      // A strobe on the channel being issued refills the buffer without loss.
      r_pend <= bus.reqSt | (r_pend & ~w_issVec);
      r_ovf  <= (bus.ovfClr ? '0 : r_ovf) | (bus.reqSt & r_pend & ~w_issVec);
      if (w_gntVld) begin
        r_rrPtr    <= w_gntNext;
        r_multA    <= r_buf[w_gnt];
        r_multCoef <= r_coef[w_gnt];
      end
      r_tagVld   <= {r_tagVld[MULT_LAT-1:0], w_gntVld};
      r_tagCh[0] <= w_gnt;
      for (int k = 1; k <= MULT_LAT; k++) begin
        r_tagCh[k] <= r_tagCh[k-1];
      end
      r_outVld <= r_tagVld[MULT_LAT];
      r_outCh  <= r_tagCh[MULT_LAT];
      r_outY   <= bus.multY;
    end
  end

`ifdef GAIN_SCHED_RAMP_EN
  localparam logic [COEF_WDT-1:0] C_STEP = COEF_WDT'(RAMP_STEP);

  logic [COEF_WDT-1:0] r_tgt  [N_CH];
  logic [COEF_WDT-1:0] w_step [N_CH];

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_step[i] = r_tgt[i];
      if (r_tgt[i] > r_coef[i]) begin
        if (r_tgt[i] - r_coef[i] > C_STEP) w_step[i] = r_coef[i] + C_STEP;
      end else begin
        if (r_coef[i] - r_tgt[i] > C_STEP) w_step[i] = r_coef[i] - C_STEP;
      end
    end
  end

  // The issue samples r_coef before this update, so it sees the pre-step value.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (reset) begin
        r_tgt[i]  <= C_UNITY;
        r_coef[i] <= C_UNITY;
      end else begin
        if (w_cfgVec[i]) r_tgt[i]  <= bus.cfgCoef;
        if (w_issVec[i]) r_coef[i] <= w_step[i];
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (reset) begin
        r_coef[i] <= C_UNITY;
      end else if (w_cfgVec[i]) begin
        r_coef[i] <= bus.cfgCoef;
      end
    end
  end
`endif

  assign bus.ovf      = r_ovf;
  assign bus.multSt   = r_tagVld[0];
  assign bus.multA    = r_multA;
  assign bus.multCoef = r_multCoef;
  assign bus.outVld   = r_outVld;
  assign bus.outCh    = r_outCh;
  assign bus.outY     = r_outY;

  // Every tagged slot must meet a multiplier result; stray rdy after reset is tolerated.
  a_tag_rdy: assert property (@(posedge clk) disable iff (reset)
                              r_tagVld[MULT_LAT] |-> bus.multRdy);

endmodule
`default_nettype wire
